// File: rtl/ram_arbiter_if.sv
// Requester, bus and RAM-port signals shared by the arbiter and its neighbours.
// The master modport is the arbiter side. The slave modport is the requesters plus the RAM.
interface ram_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;

    logic              bus_req;
    logic              bus_we;
    logic [1:0]        bus_size;
    logic [ADDR_W-1:0] bus_addr;
    logic [63:0]       bus_wdata;
    logic              bus_ack;
    logic [63:0]       bus_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [1:0]        ram_size;
    logic [ADDR_W-1:0] ram_addr;
    logic [63:0]       ram_wdata;
    logic [63:0]       ram_rdata;

    modport master (
        input  if_req, if_addr, bus_req, bus_we, bus_size, bus_addr, bus_wdata, ram_rdata,
        output if_ack, if_rdata, bus_ack, bus_rdata,
        output ram_en, ram_we, ram_size, ram_addr, ram_wdata
    );

    modport slave (
        output if_req, if_addr, bus_req, bus_we, bus_size, bus_addr, bus_wdata, ram_rdata,
        input  if_ack, if_rdata, bus_ack, bus_rdata,
        input  ram_en, ram_we, ram_size, ram_addr, ram_wdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin sharing of one fixed-latency RAM port between instruction fetch and the data bus.
// Ack arrives RAM_LAT+2 cycles after the request is sampled; requesters hold req until ack.
module ram_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int RAM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.master ifc
);
    localparam int CNT_W = (RAM_LAT < 2) ? 1 : $clog2(RAM_LAT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic              last_bus;
    logic              win_bus;
    logic              grant_if, grant_bus;
    logic [ADDR_W-1:0] addr_sel;
    logic [63:0]       bus_rd_n;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        grant_if  = 1'b0;
        grant_bus = 1'b0;
        case (state)
            IDLE: begin
                if (ifc.if_req && ifc.bus_req) begin
                    if (last_bus) grant_if  = 1'b1;
                    else          grant_bus = 1'b1;
                end else if (ifc.if_req) begin
                    grant_if = 1'b1;
                end else if (ifc.bus_req) begin
                    grant_bus = 1'b1;
                end
                if (grant_if || grant_bus) state_n = WAIT;
            end
            WAIT:    if (cnt == '0) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign addr_sel = grant_bus ? ifc.bus_addr : ifc.if_addr;

    always_comb begin
        bus_rd_n = ifc.ram_rdata;
        case (ifc.ram_size)
            2'd0:    bus_rd_n = {56'h0, ifc.ram_rdata[7:0]};
            2'd1:    bus_rd_n = {48'h0, ifc.ram_rdata[15:0]};
            2'd2:    bus_rd_n = {32'h0, ifc.ram_rdata[31:0]};
            default: bus_rd_n = ifc.ram_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifc.ram_en    <= 1'b0;
            ifc.ram_we    <= 1'b0;
            ifc.ram_size  <= 2'd0;
            ifc.ram_addr  <= '0;
            ifc.ram_wdata <= 64'h0;
            ifc.if_ack    <= 1'b0;
            ifc.bus_ack   <= 1'b0;
            ifc.if_rdata  <= 32'h0;
            ifc.bus_rdata <= 64'h0;
            cnt           <= '0;
            last_bus      <= 1'b0;
            win_bus       <= 1'b0;
        end else begin
            ifc.ram_en  <= 1'b0;
            ifc.if_ack  <= 1'b0;
            ifc.bus_ack <= 1'b0;

            if (grant_if || grant_bus) begin
                ifc.ram_en   <= 1'b1;
                ifc.ram_addr <= addr_sel;
                ifc.ram_we   <= grant_bus & ifc.bus_we;
                ifc.ram_size <= grant_bus ? ifc.bus_size : 2'd2;
                if (grant_bus) ifc.ram_wdata <= ifc.bus_wdata;
                win_bus <= grant_bus;
                cnt     <= CNT_W'(RAM_LAT);
            end

            // cnt reaches zero in the one cycle where ram_rdata is valid
            if (state == WAIT) begin
                if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end else if (win_bus) begin
                    ifc.bus_ack <= 1'b1;
                    if (!ifc.ram_we) ifc.bus_rdata <= bus_rd_n;
                end else begin
                    ifc.if_ack   <= 1'b1;
                    ifc.if_rdata <= ifc.ram_rdata[31:0];
                end
            end

            if (state == DONE) last_bus <= win_bus;
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios at RAM_LAT=1 and RAM_LAT=3 plus a random phase
// scored against a requester-level model of latency, round-robin fairness and data width.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic rst1, rst3;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_arbiter_if #(.ADDR_W(16)) i1 ();
    ram_arbiter_if #(.ADDR_W(16)) i3 ();

    ram_arbiter #(.ADDR_W(16), .RAM_LAT(1)) dut1 (.clk(clk), .rst(rst1), .ifc(i1));
    ram_arbiter #(.ADDR_W(16), .RAM_LAT(3)) dut3 (.clk(clk), .rst(rst3), .ifc(i3));

    function automatic logic [63:0] mem_f(input logic [15:0] a);
        logic [15:0] m;
        m = a * 16'd7;
        return {a ^ 16'hA5C3, ~a, m, a + 16'h1234};
    endfunction

    function automatic logic [63:0] msk(input logic [63:0] d, input logic [1:0] s);
        case (s)
            2'd0:    return {56'h0, d[7:0]};
            2'd1:    return {48'h0, d[15:0]};
            2'd2:    return {32'h0, d[31:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [63:0] low32(input logic [63:0] d);
        return {32'h0, d[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // RAM models: read data valid only RAM_LAT cycles after the edge sampling ram_en, junk otherwise
    logic        use_dir = 1'b0;
    logic [63:0] dir_dat = 64'h0;
    logic [63:0] ram1_q, p0, p1, ram3_q;
    always @(posedge clk) begin
        if (i1.ram_en && !i1.ram_we) ram1_q <= use_dir ? dir_dat : mem_f(i1.ram_addr);
        else                         ram1_q <= {$urandom, $urandom};
        if (i3.ram_en && !i3.ram_we) p0 <= mem_f(i3.ram_addr);
        else                         p0 <= {$urandom, $urandom};
        p1     <= p0;
        ram3_q <= p1;
    end
    assign i1.ram_rdata = ram1_q;
    assign i3.ram_rdata = ram3_q;

    logic prev_en1 = 1'b0, prev_en3 = 1'b0;
    always @(negedge clk) begin
        if (i1.if_ack || i1.bus_ack) chk("ack_excl1", {63'h0, i1.if_ack & i1.bus_ack}, 64'h0);
        if (i3.if_ack || i3.bus_ack) chk("ack_excl3", {63'h0, i3.if_ack & i3.bus_ack}, 64'h0);
        if (i1.ram_en) chk("en_consec1", {63'h0, prev_en1}, 64'h0);
        if (i3.ram_en) chk("en_consec3", {63'h0, prev_en3}, 64'h0);
        prev_en1 <= i1.ram_en;
        prev_en3 <= i3.ram_en;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus_op(input logic we, input logic [1:0] sz, input logic [15:0] a,
                          input logic [63:0] wd, output int lat, output int ens,
                          output logic en_we, output logic [15:0] en_addr, output logic [63:0] en_wd);
        i1.bus_we = we; i1.bus_size = sz; i1.bus_addr = a; i1.bus_wdata = wd; i1.bus_req = 1'b1;
        lat = -1; ens = 0; en_we = 1'bx; en_addr = 'x; en_wd = 'x;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            tick();
            if (i1.ram_en) begin
                ens++; en_we = i1.ram_we; en_addr = i1.ram_addr; en_wd = i1.ram_wdata;
            end
            if (i1.bus_ack) lat = n;
        end
        i1.bus_req = 1'b0;
    endtask

    task automatic check_reset1(input string tag);
        chk({tag, "_en"},    {63'h0, i1.ram_en},    64'h0);
        chk({tag, "_we"},    {63'h0, i1.ram_we},    64'h0);
        chk({tag, "_size"},  {62'h0, i1.ram_size},  64'h0);
        chk({tag, "_addr"},  {48'h0, i1.ram_addr},  64'h0);
        chk({tag, "_wdata"}, i1.ram_wdata,          64'h0);
        chk({tag, "_ifack"}, {63'h0, i1.if_ack},    64'h0);
        chk({tag, "_bsack"}, {63'h0, i1.bus_ack},   64'h0);
        chk({tag, "_ifrd"},  {32'h0, i1.if_rdata},  64'h0);
        chk({tag, "_bsrd"},  i1.bus_rdata,          64'h0);
    endtask

    int          lat, ens, acks;
    logic        e_we;
    logic [15:0] e_addr;
    logic [63:0] e_wd, tmp;
    logic        if_act, bus_act, last_bus, mif, mbus;
    int          if_iss, bus_iss, t;
    logic [15:0] r_if_addr, r_bus_addr;
    logic        r_bus_we;
    logic [1:0]  r_bus_size;
    logic [63:0] r_bus_wd, bus_rd_model;

    initial begin
        i1.if_req = 0; i1.if_addr = 0; i1.bus_req = 0; i1.bus_we = 0; i1.bus_size = 0;
        i1.bus_addr = 0; i1.bus_wdata = 0;
        i3.if_req = 0; i3.if_addr = 0; i3.bus_req = 0; i3.bus_we = 0; i3.bus_size = 0;
        i3.bus_addr = 0; i3.bus_wdata = 0;
        rst1 = 1; rst3 = 1;
        tick(); tick();
        check_reset1("rst");
        rst1 = 0; rst3 = 0;

        // fetch: ram_en in cycle 1, ack in cycle 3
        use_dir = 1; dir_dat = 64'h00000000_1020304A;
        i1.if_addr = 16'h0010; i1.if_req = 1;
        tick();
        chk("if_en_c1",   {63'h0, i1.ram_en},   64'h1);
        chk("if_addr_c1", {48'h0, i1.ram_addr}, 64'h0010);
        chk("if_size_c1", {62'h0, i1.ram_size}, 64'h2);
        chk("if_we_c1",   {63'h0, i1.ram_we},   64'h0);
        tick();
        chk("if_en_c2",   {63'h0, i1.ram_en},   64'h0);
        chk("if_ack_c2",  {63'h0, i1.if_ack},   64'h0);
        tick();
        chk("if_ack_c3",  {63'h0, i1.if_ack},   64'h1);
        chk("if_rdata",   {32'h0, i1.if_rdata}, 64'h1020304A);
        i1.if_req = 0;
        tick();
        chk("if_ack_c4",  {63'h0, i1.if_ack},   64'h0);

        dir_dat = 64'hFFFF_FFFF_FFFF_FFAB;
        bus_op(0, 2'd0, 16'h0020, 64'h0, lat, ens, e_we, e_addr, e_wd);
        chk("rd_b_lat",   lat, 3);
        chk("rd_b_data",  i1.bus_rdata, 64'h0000_0000_0000_00AB);
        tick();
        bus_op(0, 2'd1, 16'h0022, 64'h0, lat, ens, e_we, e_addr, e_wd);
        chk("rd_w_lat",   lat, 3);
        chk("rd_w_data",  i1.bus_rdata, 64'h0000_0000_0000_FFAB);
        tick();

        bus_op(1, 2'd0, 16'h0100, 64'h55, lat, ens, e_we, e_addr, e_wd);
        chk("wr_lat",     lat, 3);
        chk("wr_ens",     ens, 1);
        chk("wr_we",      {63'h0, e_we},   64'h1);
        chk("wr_addr",    {48'h0, e_addr}, 64'h0100);
        chk("wr_wdata",   e_wd,            64'h55);
        chk("wr_hold_rd", i1.bus_rdata,    64'h0000_0000_0000_FFAB);
        tick();
        use_dir = 0;

        // requester misbehaves in WAIT: the latched access still completes once
        i1.bus_we = 0; i1.bus_size = 2'd3; i1.bus_addr = 16'h0200; i1.bus_req = 1;
        tick();
        chk("drop_en",    {63'h0, i1.ram_en},   64'h1);
        i1.bus_req = 0; i1.bus_addr = 16'h0333;
        tick();
        chk("drop_addr2", {48'h0, i1.ram_addr}, 64'h0200);
        tick();
        chk("drop_ack",   {63'h0, i1.bus_ack},  64'h1);
        chk("drop_addr3", {48'h0, i1.ram_addr}, 64'h0200);
        chk("drop_data",  i1.bus_rdata,         mem_f(16'h0200));
        acks = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (i1.bus_ack || i1.ram_en) acks++;
        end
        chk("drop_once",  acks, 0);

        // simultaneous requests after reset alternate, bus first
        rst1 = 1; tick(); tick(); rst1 = 0;
        i1.if_addr = 16'h0400; i1.bus_addr = 16'h0500; i1.bus_size = 2'd3; i1.bus_we = 0;
        i1.if_req = 1; i1.bus_req = 1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            chk($sformatf("tie_bus_c%0d", n), {63'h0, i1.bus_ack},
                {63'h0, (n % 4 == 3) && ((n / 4) % 2 == 0)});
            chk($sformatf("tie_if_c%0d", n), {63'h0, i1.if_ack},
                {63'h0, (n % 4 == 3) && ((n / 4) % 2 == 1)});
        end
        chk("tie_bus_rd", i1.bus_rdata, mem_f(16'h0500));
        chk("tie_if_rd",  {32'h0, i1.if_rdata}, low32(mem_f(16'h0400)));
        i1.if_req = 0; i1.bus_req = 0;

        // random traffic against the requester-level model
        rst1 = 1; tick(); tick(); rst1 = 0;
        if_act = 0; bus_act = 0; last_bus = 0; bus_rd_model = 64'h0; if_iss = 0; bus_iss = 0;
        r_if_addr = 0; r_bus_addr = 0; r_bus_we = 0; r_bus_size = 0; r_bus_wd = 0;
        for (int k = 0; k < 600; k++) begin
            if (!if_act && $urandom_range(0, 2) == 0) begin
                if_act = 1; if_iss = cyc; r_if_addr = 16'($urandom);
                i1.if_addr = r_if_addr; i1.if_req = 1;
            end
            if (!bus_act && $urandom_range(0, 2) == 0) begin
                bus_act = 1; bus_iss = cyc; r_bus_addr = 16'($urandom);
                r_bus_we = ($urandom_range(0, 3) == 0); r_bus_size = 2'($urandom_range(0, 3));
                r_bus_wd = {$urandom, $urandom};
                i1.bus_addr = r_bus_addr; i1.bus_we = r_bus_we; i1.bus_size = r_bus_size;
                i1.bus_wdata = r_bus_wd; i1.bus_req = 1;
            end
            tick();
            t = cyc;
            if (i1.ram_en) begin
                mif  = if_act && !i1.ram_we && i1.ram_size == 2'd2 && i1.ram_addr == r_if_addr;
                mbus = bus_act && i1.ram_we == r_bus_we && i1.ram_size == r_bus_size &&
                       i1.ram_addr == r_bus_addr && (!r_bus_we || i1.ram_wdata == r_bus_wd);
                chk("rnd_ram_port", {63'h0, mif | mbus}, 64'h1);
            end
            if (i1.if_ack) begin
                chk("rnd_if_owner", {63'h0, if_act}, 64'h1);
                chk("rnd_if_rd", {32'h0, i1.if_rdata}, low32(mem_f(r_if_addr)));
                chk("rnd_if_lat", {63'h0, (t - if_iss) >= 3}, 64'h1);
                if (bus_act && bus_iss <= t - 3) chk("rnd_rr_if", {63'h0, last_bus}, 64'h1);
                last_bus = 0; if_act = 0; i1.if_req = 0;
            end
            if (i1.bus_ack) begin
                chk("rnd_bus_owner", {63'h0, bus_act}, 64'h1);
                if (!r_bus_we) bus_rd_model = msk(mem_f(r_bus_addr), r_bus_size);
                chk("rnd_bus_rd", i1.bus_rdata, bus_rd_model);
                chk("rnd_bus_lat", {63'h0, (t - bus_iss) >= 3}, 64'h1);
                if (if_act && if_iss <= t - 3) chk("rnd_rr_bus", {63'h0, last_bus}, 64'h0);
                last_bus = 1; bus_act = 0; i1.bus_req = 0;
            end
            if (if_act && (t - if_iss) > 12) begin
                chk("rnd_if_timeout", {63'h0, if_act}, 64'h0);
                if_act = 0; i1.if_req = 0;
            end
            if (bus_act && (t - bus_iss) > 12) begin
                chk("rnd_bus_timeout", {63'h0, bus_act}, 64'h0);
                bus_act = 0; i1.bus_req = 0;
            end
        end
        i1.if_req = 0; i1.bus_req = 0;
        tick(); tick(); tick(); tick();

        // RAM_LAT=3: full fetch, then a fetch cut by reset, then a normal bus read
        i3.if_addr = 16'h0040; i3.if_req = 1; lat = -1;
        for (int n = 1; n <= 12 && lat < 0; n++) begin
            tick();
            if (i3.if_ack) lat = n;
        end
        i3.if_req = 0;
        chk("l3_if_lat", lat, 5);
        chk("l3_if_rd",  {32'h0, i3.if_rdata}, low32(mem_f(16'h0040)));
        tick();
        i3.if_addr = 16'h0044; i3.if_req = 1;
        tick();
        chk("l3_en_c1", {63'h0, i3.ram_en}, 64'h1);
        tick();
        rst3 = 1;
        tick();
        rst3 = 0; i3.if_req = 0;
        chk("l3_rst_en",   {63'h0, i3.ram_en},   64'h0);
        chk("l3_rst_size", {62'h0, i3.ram_size}, 64'h0);
        chk("l3_rst_addr", {48'h0, i3.ram_addr}, 64'h0);
        chk("l3_rst_ack",  {63'h0, i3.if_ack},   64'h0);
        chk("l3_rst_ifrd", {32'h0, i3.if_rdata}, 64'h0);
        acks = 0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (i3.if_ack) acks++;
        end
        chk("l3_no_ack", acks, 0);
        i3.bus_we = 0; i3.bus_size = 2'd2; i3.bus_addr = 16'h0048; i3.bus_req = 1; lat = -1;
        for (int n = 1; n <= 12 && lat < 0; n++) begin
            tick();
            if (i3.bus_ack) lat = n;
        end
        i3.bus_req = 0;
        chk("l3_bus_lat", lat, 5);
        chk("l3_bus_rd",  i3.bus_rdata, msk(mem_f(16'h0048), 2'd2));
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
